lcb_rx_framer: RTL

LCB_RX_FRAMER -- requirements
Module: lcb_rx_framer

---
 rtl/lcb_rx_pkg.sv | 15 +
 rtl/lcb_rx_timer.sv | 29 ++
 rtl/lcb_rx_framer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lcb_rx_pkg.sv
// Shared types and defaults for the UART frame receiver (one framer per UART channel).
package lcb_rx_pkg;

    localparam int unsigned ADR_W = 5;

    localparam logic [ADR_W-1:0] BYTES_DEF   = 5'd4;
    localparam logic [15:0]      TIMEOUT_DEF = 16'd1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lcb_rx_timer.sv
// Inter-byte watchdog: 16-bit counter, cleared by clr, advancing while en is high.
// expire is combinational from the count so the framer can let a same-cycle strob win.
module lcb_rx_timer
    import lcb_rx_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [15:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign expire = en && (r_cnt == (TIMEOUT - 16'd1));

endmodule

// File: rtl/lcb_rx_framer.sv
// Frame receiver for one UART channel: writes BYTES bytes into frame RAM, checks the trailing
// additive checksum and flags timeout/overrun. WE one cycle after strob, verdict two; no backpressure.
module lcb_rx_framer
    import lcb_rx_pkg::*;
#(
    parameter logic [ADR_W-1:0] BYTES   = BYTES_DEF,
    parameter logic [15:0]      TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strob,
    input  logic [7:0]       iData,
    output logic [7:0]       wrData,
    output logic [ADR_W-1:0] wrAdr,
    output logic             WE,
    output logic             full,
    output logic             errSum,
    output logic             errTime,
    output logic             errOvr,
    output logic [7:0]       frameCnt
);

    state_t           r_state;
    logic [ADR_W-1:0] r_idx;
    logic [7:0]       r_sum;
    logic [7:0]       r_wrData;
    logic [ADR_W-1:0] r_wrAdr;
    logic             r_we;
    logic             r_full;
    logic             r_errSum;
    logic             r_errTime;
    logic             r_errOvr;
    logic [7:0]       r_frameCnt;

    state_t           w_state_nxt;
    logic [ADR_W-1:0] w_idx_nxt;
    logic [7:0]       w_sum_nxt;
    logic [7:0]       w_wrData_nxt;
    logic [ADR_W-1:0] w_wrAdr_nxt;
    logic             w_we_nxt;
    logic             w_full_nxt;
    logic             w_errSum_nxt;
    logic             w_errTime_nxt;
    logic             w_errOvr_nxt;
    logic [7:0]       w_frameCnt_nxt;
    logic             w_accept;
    logic             w_expire;
    logic             w_tmr_en;
    logic             w_tmr_clr;

    // Timer runs only in RECV and is held at zero everywhere else.
    assign w_tmr_en  = (r_state == RECV);
    assign w_tmr_clr = w_accept || (w_state_nxt != RECV);

    lcb_rx_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_tmr_clr),
        .en     (w_tmr_en),
        .expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_sum      <= '0;
            r_wrData   <= '0;
            r_wrAdr    <= '0;
            r_we       <= 1'b0;
            r_full     <= 1'b0;
            r_errSum   <= 1'b0;
            r_errTime  <= 1'b0;
            r_errOvr   <= 1'b0;
            r_frameCnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_sum      <= w_sum_nxt;
            r_wrData   <= w_wrData_nxt;
            r_wrAdr    <= w_wrAdr_nxt;
            r_we       <= w_we_nxt;
            r_full     <= w_full_nxt;
            r_errSum   <= w_errSum_nxt;
            r_errTime  <= w_errTime_nxt;
            r_errOvr   <= w_errOvr_nxt;
            r_frameCnt <= w_frameCnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_sum_nxt      = r_sum;
        w_wrData_nxt   = r_wrData;
        w_wrAdr_nxt    = r_wrAdr;
        w_we_nxt       = 1'b0;
        w_full_nxt     = 1'b0;
        w_errSum_nxt   = 1'b0;
        w_errTime_nxt  = 1'b0;
        w_errOvr_nxt   = 1'b0;
        w_frameCnt_nxt = r_frameCnt;
        w_accept       = 1'b0;

        case (r_state)
            IDLE: begin
                if (strob) begin
                    w_accept     = 1'b1;
                    w_wrData_nxt = iData;
                    w_wrAdr_nxt  = '0;
                    w_we_nxt     = 1'b1;
                    w_sum_nxt    = iData;
                    w_idx_nxt    = 5'd1;
                    w_state_nxt  = RECV;
                end
            end
            RECV: begin
                if (strob) begin
                    w_accept     = 1'b1;
                    w_wrData_nxt = iData;
                    w_wrAdr_nxt  = r_idx;
                    w_we_nxt     = 1'b1;
                    // The checksum byte itself is held in r_wrData for the DONE compare.
                    if (r_idx == (BYTES - 5'd1)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_sum_nxt = r_sum + iData;
                        w_idx_nxt = r_idx + 5'd1;
                    end
                end else if (w_expire) begin
                    w_errTime_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                    w_idx_nxt     = '0;
                    w_sum_nxt     = '0;
                end
            end
            DONE: begin
                if (r_wrData == r_sum) begin
                    w_full_nxt     = 1'b1;
                    w_frameCnt_nxt = r_frameCnt + 8'd1;
                end else begin
                    w_errSum_nxt = 1'b1;
                end
                w_errOvr_nxt = strob;
                w_state_nxt  = IDLE;
                w_idx_nxt    = '0;
                w_sum_nxt    = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
                w_sum_nxt   = '0;
            end
        endcase
    end

    assign wrData   = r_wrData;
    assign wrAdr    = r_wrAdr;
    assign WE       = r_we;
    assign full     = r_full;
    assign errSum   = r_errSum;
    assign errTime  = r_errTime;
    assign errOvr   = r_errOvr;
    assign frameCnt = r_frameCnt;

endmodule
